// File: rtl/golden_nonce_collector.sv
// Golden nonce collector: delays issued nonces to line up with the hash validator's
// success flag, queues winning nonces in a small FWFT FIFO and counts checked hashes.
module golden_nonce_collector #(
   parameter int unsigned LATENCY = 66,
   parameter int unsigned DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        job_start,
   input  logic        nonce_valid,
   input  logic [31:0] nonce,
   input  logic        success,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_nonce,
   output logic [31:0] hash_count,
   output logic        overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [LATENCY-1:0] dl_valid;
   logic [31:0]        dl_nonce [LATENCY];
   logic [31:0]        mem [DEPTH];
   logic [AW-1:0]      rd_ptr;
   logic [AW-1:0]      wr_ptr;
   logic [CW-1:0]      count;

   logic               tag_valid;
   logic [31:0]        tag_nonce;
   logic               candidate;
   logic               full;
   logic               pop;
   logic               push;
   logic               drop;
   logic [CW-1:0]      count_next;

   // Tag leaving the delay line pairs with this cycle's success flag
   always_comb begin
      tag_valid  = dl_valid[LATENCY-1];
      tag_nonce  = dl_nonce[LATENCY-1];
      candidate  = tag_valid & success;
      full       = (count == CW'(DEPTH));
      pop        = out_valid & out_ready;
      push       = candidate & (~full | pop);
      drop       = candidate & full & ~pop;
      count_next = count + CW'(push) - CW'(pop);
   end

   // Valid bits clear on job_start; stage 0 always takes this cycle's input
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dl_valid <= '0;
      end else begin
         dl_valid[0] <= nonce_valid;
         for (int i = 1; i < int'(LATENCY); i++) begin
            dl_valid[i] <= job_start ? 1'b0 : dl_valid[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      dl_nonce[0] <= nonce;
      for (int i = 1; i < int'(LATENCY); i++) begin
         dl_nonce[i] <= dl_nonce[i-1];
      end
   end

   // Result FIFO, hit counter and sticky overflow; job_start wins over everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         out_valid  <= 1'b0;
         hash_count <= '0;
         overflow   <= 1'b0;
      end else if (job_start) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         out_valid  <= 1'b0;
         hash_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= tag_nonce;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count     <= count_next;
         out_valid <= (count_next != '0);
         if (tag_valid && (hash_count != 32'hFFFF_FFFF)) begin
            hash_count <= hash_count + 32'd1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Head entry read straight from storage for fall-through
   assign out_nonce = mem[rd_ptr];

endmodule

// File: doc/golden_nonce_collector.md
GOLDEN_NONCE_COLLECTOR -- requirements
Module: golden_nonce_collector

Interface
REQ-001 SHALL have parameter LATENCY, default 66; cycles from nonce issue to the matching success flag at this block's input; legal range 1..255.
REQ-002 SHALL have parameter DEPTH, default 4; result FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1; sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1; reset, asynchronous, active-high.
REQ-005 SHALL have port job_start, input, 1; one-cycle pulse that starts a new job and clears all job state.
REQ-006 SHALL have port nonce_valid, input, 1; a nonce enters the hash pipeline this cycle.
REQ-007 SHALL have port nonce, input, 32; nonce value qualified by nonce_valid.
REQ-008 SHALL have port success, input, 1; registered hash-below-target flag from the hash validator.
REQ-009 SHALL have port out_valid, output, 1; head FIFO entry available.
REQ-010 SHALL have port out_ready, input, 1; consumer accepts the head entry.
REQ-011 SHALL have port out_nonce, output, 32; winning nonce at the FIFO head.
REQ-012 SHALL have port hash_count, output, 32; number of tagged hashes checked this job.
REQ-013 SHALL have port overflow, output, 1; sticky flag, set when a winning nonce was dropped.

Function
REQ-014 SHALL delay {nonce_valid, nonce} through exactly LATENCY register stages, advancing every cycle with no stall, so the tag leaving the line at cycle T pairs with success at cycle T.
REQ-015 SHALL treat a cycle as a candidate only when the delayed tag valid is 1 and success is 1; success with an invalid tag SHALL be ignored.
REQ-016 SHALL push the delayed nonce of a candidate into the FIFO on the same clock edge; the nonce issued at cycle N with success at N+LATENCY SHALL appear on out_valid/out_nonce at N+LATENCY+1.
REQ-017 SHALL pop the head entry on any edge where out_valid and out_ready are both 1.
REQ-018 SHALL hold out_nonce and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL deliver entries in push order, first-word fall-through, with no combinational path from out_ready to out_valid.
REQ-020 SHALL accept a push on a full FIFO when a pop occurs on the same edge; occupancy stays at DEPTH.
REQ-021 SHALL drop the candidate on a full FIFO with no pop, keep FIFO contents unchanged, and set overflow to 1 from the next cycle.
REQ-022 SHALL accept a push and a pop on the same edge on an empty-to-one FIFO or a partially full FIFO, leaving occupancy unchanged.
REQ-023 SHALL increment hash_count by 1 for each valid delayed tag, whatever the value of success, and saturate at 0xFFFFFFFF.
REQ-024 SHALL, on an edge with job_start=1, clear all delay-line valid bits, empty the FIFO, and zero hash_count and overflow.
REQ-025 SHALL give job_start priority over any push, pop, count increment or overflow set on that same edge.
REQ-026 SHALL load nonce_valid/nonce presented in the job_start cycle into the cleared delay line as the first nonce of the new job.
REQ-027 SHALL leave out_nonce value unspecified while out_valid=0.

Reset
REQ-028 SHALL, while rst=1 and independent of clk, drive out_valid=0, out_nonce=0, hash_count=0 and overflow=0, empty the FIFO, and clear all delay-line valid bits.
REQ-029 SHALL discard any in-flight nonces and FIFO contents when rst asserts mid-operation; after release, behaviour SHALL equal power-up.
REQ-030 SHALL resume normal operation on the first rising edge after rst deasserts.

Verification (bench uses LATENCY=4, DEPTH=4)
REQ-031 Single win: nonce 0x00000010 valid at cycle 0, success=1 at cycle 4, out_ready=1 -> out_valid=1 with out_nonce=0x00000010 at cycle 5 only; hash_count=1.
REQ-032 Tag gating: success=1 at cycles 2..6, with only nonce 0xA valid at cycle 1 -> exactly one entry 0xA; hash_count=1.
REQ-033 Backpressure and overflow: out_ready=0, five consecutive winning nonces 1..5 -> FIFO holds 1..4 and overflow=1; with out_ready then raised -> outputs 1,2,3,4 in order.
REQ-034 Full with simultaneous pop: FIFO full (1..4), push 5 with out_ready=1 on the same edge -> overflow stays 0; subsequent outputs 2,3,4,5.
REQ-035 Job restart: three nonces in flight plus two FIFO entries, job_start pulse -> out_valid=0, hash_count=0 and overflow=0 next cycle; the nonce issued in the job_start cycle is counted 4 cycles later.
REQ-036 Async reset: rst asserted between clock edges with FIFO non-empty -> out_valid=0 and hash_count=0 immediately, before the next edge.
